// File: rtl/ps2_host_tx_if.sv
// Host-side command handshake for the PS/2 transmitter: byte + start in,
// busy/done/error status out.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       busy;
  logic       done;
  logic       error;

  modport master (output tx_data, tx_start, input busy, done, error);
  modport slave  (input tx_data, tx_start, output busy, done, error);
endinterface

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter (open-collector pull-low enables).
// Optional PS2_TX_TIMEOUT_EN aborts a stalled frame after TIMEOUT_CYCLES.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 2400,
  parameter int TIMEOUT_CYCLES = 360000,
  parameter int CNT_W          = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ps2clk_in,
  input  logic ps2dat_in,
  output logic ps2clk_oe,
  output logic ps2dat_oe,
  ps2_host_tx_if.slave host
);

  typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SEND, ACK, WAITIDLE} state_t;

  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state, state_n;
  logic [1:0]       csync, dsync;
  logic             c_hist;
  logic             clk_s, dat_s, fall;
  logic [8:0]       sh;
  logic [3:0]       ecnt;
  logic [CNT_W-1:0] cnt;
  logic             dat_q, busy_q, done_q, err_q;
  logic             done_n, err_n;

  assign clk_s = csync[1];
  assign dat_s = dsync[1];
  assign fall  = c_hist & ~clk_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    done_n  = 1'b0;
    err_n   = 1'b0;
    unique case (state)
      IDLE:     if (host.tx_start) state_n = INHIBIT;
      INHIBIT:  if (cnt == INH_LAST) state_n = REQ;
      REQ:      state_n = SEND;
      SEND:     if (fall && ecnt == 4'd9) state_n = ACK;
      ACK: if (fall) begin
        if (dat_s) begin
          err_n   = 1'b1;
          state_n = IDLE;
        end else begin
          state_n = WAITIDLE;
        end
      end
      WAITIDLE: if (clk_s && dat_s) begin
        done_n  = 1'b1;
        state_n = IDLE;
      end
      default:  state_n = IDLE;
    endcase
`ifdef PS2_TX_TIMEOUT_EN
    // Timeout wins over a coincident ack so done and error stay exclusive.
    if ((state == SEND || state == ACK || state == WAITIDLE) && cnt == TMO_LAST) begin
      state_n = IDLE;
      done_n  = 1'b0;
      err_n   = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csync  <= 2'b11;
      dsync  <= 2'b11;
      c_hist <= 1'b1;
      sh     <= '0;
      ecnt   <= '0;
      cnt    <= '0;
      dat_q  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      csync  <= {csync[0], ps2clk_in};
      dsync  <= {dsync[0], ps2dat_in};
      c_hist <= clk_s;
      busy_q <= (state_n != IDLE);
      done_q <= done_n;
      err_q  <= err_n;
      unique case (state)
        IDLE: if (host.tx_start) begin
          sh   <= {~^host.tx_data, host.tx_data};
          cnt  <= '0;
          ecnt <= '0;
        end
        INHIBIT: begin
          cnt <= cnt + 1'b1;
          // Start bit goes low together with the last inhibited clock cycle.
          if (state_n == REQ) dat_q <= 1'b1;
        end
        REQ: begin
          cnt  <= '0;
          ecnt <= '0;
        end
        SEND, ACK, WAITIDLE: begin
`ifdef PS2_TX_TIMEOUT_EN
          cnt <= cnt + 1'b1;
`else
          // No abort without the timeout; hold at the limit rather than wrap.
          if (cnt != TMO_LAST) cnt <= cnt + 1'b1;
`endif
          if (state == SEND && fall) begin
            ecnt <= ecnt + 1'b1;
            if (ecnt == 4'd9) begin
              dat_q <= 1'b0;
            end else begin
              dat_q <= ~sh[0];
              sh    <= {1'b0, sh[8:1]};
            end
          end
        end
        default: ;
      endcase
      if (state_n == IDLE) dat_q <= 1'b0;
    end
  end

  assign ps2clk_oe  = (state == INHIBIT) || (state == REQ);
  assign ps2dat_oe  = dat_q;
  assign host.busy  = busy_q;
  assign host.done  = done_q;
  assign host.error = err_q;

endmodule
